// File: rtl/sc_microseq_pkg.sv
// ----------------------------------------------------------------------------
// sc_microseq_pkg
// Shared definitions for the sc_microsequencer slice:
//   - cond_e  : branch-condition encodings of the microinstruction cond field
//   - state_e : sequencer states
//   - instr_w / ctl_w : microinstruction and control-field widths
//   - shifter idle level for the active-low shifter strobes
// No ports (package).
// ----------------------------------------------------------------------------
package sc_microseq_pkg;

  localparam int COND_W = 3;
  localparam int WDOG_W = 8;

  // Active-low shifter strobes are idle high.
  localparam logic SHIFTER_IDLE_N = 1'b1;

  typedef enum logic [COND_W-1:0] {
    COND_NEXT  = 3'd0,
    COND_JUMP  = 3'd1,
    COND_ZERO  = 3'd2,
    COND_NEG   = 3'd3,
    COND_CARRY = 3'd4,
    COND_OVF   = 3'd5,
    COND_NZERO = 3'd6,
    COND_HALT  = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Word layout MSB->LSB:
  //   load_sel, clear_sel, muxA, muxB, alu, shclr_n, shld_n, shsel, cond, target
  function automatic int instr_w(int dec_w, int mux_w, int alu_w, int sh_w, int pc_w);
    return 2*dec_w + 2*mux_w + alu_w + 2 + sh_w + COND_W + pc_w;
  endfunction

  // Width of the control portion (everything above cond/target).
  function automatic int ctl_w(int dec_w, int mux_w, int alu_w, int sh_w);
    return 2*dec_w + 2*mux_w + alu_w + 2 + sh_w;
  endfunction

endpackage

// File: rtl/sc_microsequencer_if.sv
// ----------------------------------------------------------------------------
// sc_microsequencer_if
// Host-side handshake and program-load bus of the microsequencer.
//   start/startaddr       : launch a microprogram (master -> slave)
//   progwrite/addr/data   : microprogram store write port (master -> slave)
//   busy/done/error       : run status (slave -> master)
// Modports: master (system top / bench), slave (sequencer).
// ----------------------------------------------------------------------------
interface sc_microsequencer_if
  import sc_microseq_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = instr_w(4, 3, 4, 2, 4)
) ();

  logic               SC_MICROSEQ_start_In;
  logic [PC_W-1:0]    SC_MICROSEQ_startaddr_InBUS;
  logic               SC_MICROSEQ_progwrite_In;
  logic [PC_W-1:0]    SC_MICROSEQ_progaddr_InBUS;
  logic [INSTR_W-1:0] SC_MICROSEQ_progdata_InBUS;
  logic               SC_MICROSEQ_busy_Out;
  logic               SC_MICROSEQ_done_Out;
  logic               SC_MICROSEQ_error_Out;

  modport master (
    output SC_MICROSEQ_start_In, SC_MICROSEQ_startaddr_InBUS,
           SC_MICROSEQ_progwrite_In, SC_MICROSEQ_progaddr_InBUS,
           SC_MICROSEQ_progdata_InBUS,
    input  SC_MICROSEQ_busy_Out, SC_MICROSEQ_done_Out, SC_MICROSEQ_error_Out
  );

  modport slave (
    input  SC_MICROSEQ_start_In, SC_MICROSEQ_startaddr_InBUS,
           SC_MICROSEQ_progwrite_In, SC_MICROSEQ_progaddr_InBUS,
           SC_MICROSEQ_progdata_InBUS,
    output SC_MICROSEQ_busy_Out, SC_MICROSEQ_done_Out, SC_MICROSEQ_error_Out
  );

endinterface

// File: rtl/sc_microseq_store.sv
// ----------------------------------------------------------------------------
// sc_microseq_store
// Writable microprogram store: DEPTH x W, synchronous write, asynchronous
// read. Contents are deliberately not reset so a program survives reset.
// Ports:
//   clk_i     : clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_i   : read address (combinational read)
//   rdata_o   : read data
// ----------------------------------------------------------------------------
module sc_microseq_store #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 29
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sc_microsequencer.sv
// ----------------------------------------------------------------------------
// sc_microsequencer
// Microprogrammed control unit driving the uDATAPATH control buses from a
// writable microprogram store, with start/busy/done handshake, branching on
// the datapath's active-low flags and a watchdog abort.
//
// Ports:
//   SC_MICROSEQ_CLOCK_50        : clock
//   SC_MICROSEQ_RESET_InLow     : asynchronous active-low reset
//   SC_MICROSEQ_step_In         : single-step enable (SC_MICROSEQ_STEP_EN only)
//   ctrl                        : handshake + program-load interface (slave)
//   SC_MICROSEQ_*_InLow flags   : overflow/carry/negative/zero, active-low
//   SC_MICROSEQ_*_OutBUS/_OutLow: registered datapath control outputs
//
// Build option: define SC_MICROSEQ_STEP_EN to add SC_MICROSEQ_step_In; RUN
// then advances only on cycles with step high. Default: one word per cycle.
// ----------------------------------------------------------------------------
module sc_microsequencer
  import sc_microseq_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_SELECTION    = 4,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int PROGRAM_DEPTH                  = 16,
  parameter logic [DATAWIDTH_DECODER_SELECTION-1:0] DECODER_NOP = '1,
  parameter int WATCHDOG_MAX                   = 255
) (
  input  logic SC_MICROSEQ_CLOCK_50,
  input  logic SC_MICROSEQ_RESET_InLow,
`ifdef SC_MICROSEQ_STEP_EN
  input  logic SC_MICROSEQ_step_In,
`endif
  sc_microsequencer_if.slave ctrl,
  input  logic SC_MICROSEQ_overflow_InLow,
  input  logic SC_MICROSEQ_carry_InLow,
  input  logic SC_MICROSEQ_negative_InLow,
  input  logic SC_MICROSEQ_zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MICROSEQ_decoderclearselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MICROSEQ_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MICROSEQ_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MICROSEQ_muxselectionBUSB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_MICROSEQ_aluselection_OutBUS,
  output logic                                      SC_MICROSEQ_regSHIFTERclear_OutLow,
  output logic                                      SC_MICROSEQ_regSHIFTERload_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_MICROSEQ_regSHIFTERshiftselection_OutBUS
);

  localparam int DEC_W   = DATAWIDTH_DECODER_SELECTION;
  localparam int MUX_W   = DATAWIDTH_MUX_SELECTION;
  localparam int ALU_W   = DATAWIDTH_ALU_SELECTION;
  localparam int SH_W    = DATAWIDTH_REGSHIFTER_SELECTION;
  localparam int PC_W    = $clog2(PROGRAM_DEPTH);
  localparam int INSTR_W = instr_w(DEC_W, MUX_W, ALU_W, SH_W, PC_W);
  localparam int CTL_W   = ctl_w(DEC_W, MUX_W, ALU_W, SH_W);
  localparam int CTL_LSB = PC_W + COND_W;

  // Field offsets inside the registered control vector (LSB first).
  localparam int SHLD_POS = SH_W;
  localparam int SHCL_POS = SH_W + 1;
  localparam int ALU_LSB  = SH_W + 2;
  localparam int MUXB_LSB = ALU_LSB + ALU_W;
  localparam int MUXA_LSB = MUXB_LSB + MUX_W;
  localparam int CLR_LSB  = MUXA_LSB + MUX_W;
  localparam int LD_LSB   = CLR_LSB + DEC_W;

  localparam logic [CTL_W-1:0] CTL_NOP = {DECODER_NOP, DECODER_NOP,
                                          {(2*MUX_W + ALU_W){1'b0}},
                                          SHIFTER_IDLE_N, SHIFTER_IDLE_N,
                                          {SH_W{1'b0}}};

  // Abort fires on the RUN cycle that would make the count reach the limit,
  // so a run lasts at most WATCHDOG_MAX cycles.
  localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(WATCHDOG_MAX - 1);

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [WDOG_W-1:0]  wd_q;
  logic [CTL_W-1:0]   ctl_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;

  logic [INSTR_W-1:0] rd_word;
  cond_e              word_cond;
  logic [PC_W-1:0]    word_target;
  logic               taken;
  logic               advance;
  logic               store_we;

  assign store_we = ctrl.SC_MICROSEQ_progwrite_In && (state_q == ST_IDLE);

  sc_microseq_store #(
    .DEPTH (PROGRAM_DEPTH),
    .AW    (PC_W),
    .W     (INSTR_W)
  ) u_store (
    .clk_i   (SC_MICROSEQ_CLOCK_50),
    .we_i    (store_we),
    .waddr_i (ctrl.SC_MICROSEQ_progaddr_InBUS),
    .wdata_i (ctrl.SC_MICROSEQ_progdata_InBUS),
    .raddr_i (pc_q),
    .rdata_o (rd_word)
  );

`ifdef SC_MICROSEQ_STEP_EN
  assign advance = SC_MICROSEQ_step_In;
`else
  assign advance = 1'b1;
`endif

  assign word_cond   = cond_e'(rd_word[PC_W +: COND_W]);
  assign word_target = rd_word[PC_W-1:0];

  // Flags arrive active-low; invert here so the branch test reads naturally.
  always_comb begin
    taken = 1'b0;
    case (word_cond)
      COND_JUMP:  taken = 1'b1;
      COND_ZERO:  taken = ~SC_MICROSEQ_zero_InLow;
      COND_NEG:   taken = ~SC_MICROSEQ_negative_InLow;
      COND_CARRY: taken = ~SC_MICROSEQ_carry_InLow;
      COND_OVF:   taken = ~SC_MICROSEQ_overflow_InLow;
      COND_NZERO: taken = SC_MICROSEQ_zero_InLow;
      default:    taken = 1'b0;
    endcase
    pc_d = taken ? word_target : pc_q + PC_W'(1);
  end

  always_ff @(posedge SC_MICROSEQ_CLOCK_50 or negedge SC_MICROSEQ_RESET_InLow) begin
    if (!SC_MICROSEQ_RESET_InLow) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wd_q    <= '0;
      ctl_q   <= CTL_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ctl_q <= CTL_NOP;
          if (ctrl.SC_MICROSEQ_start_In) begin
            pc_q    <= ctrl.SC_MICROSEQ_startaddr_InBUS;
            wd_q    <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (advance) begin
            // Watchdog wins over a halt fetched on the same cycle.
            if (wd_q == WD_LAST) begin
              ctl_q   <= CTL_NOP;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else if (word_cond == COND_HALT) begin
              ctl_q   <= CTL_NOP;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              ctl_q <= rd_word[CTL_LSB +: CTL_W];
              pc_q  <= pc_d;
              wd_q  <= wd_q + WDOG_W'(1);
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ctl_q   <= CTL_NOP;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign SC_MICROSEQ_decoderloadselection_OutBUS     = ctl_q[LD_LSB +: DEC_W];
  assign SC_MICROSEQ_decoderclearselection_OutBUS    = ctl_q[CLR_LSB +: DEC_W];
  assign SC_MICROSEQ_muxselectionBUSA_OutBUS         = ctl_q[MUXA_LSB +: MUX_W];
  assign SC_MICROSEQ_muxselectionBUSB_OutBUS         = ctl_q[MUXB_LSB +: MUX_W];
  assign SC_MICROSEQ_aluselection_OutBUS             = ctl_q[ALU_LSB +: ALU_W];
  assign SC_MICROSEQ_regSHIFTERclear_OutLow          = ctl_q[SHCL_POS];
  assign SC_MICROSEQ_regSHIFTERload_OutLow           = ctl_q[SHLD_POS];
  assign SC_MICROSEQ_regSHIFTERshiftselection_OutBUS = ctl_q[SH_W-1:0];

  assign ctrl.SC_MICROSEQ_busy_Out  = busy_q;
  assign ctrl.SC_MICROSEQ_done_Out  = done_q;
  assign ctrl.SC_MICROSEQ_error_Out = error_q;

endmodule

// File: tb/tb_sc_microsequencer.sv
// ----------------------------------------------------------------------------
// tb_sc_microsequencer
// Self-checking bench for sc_microsequencer at default parameters. A
// program-level reference model turns the store image, start address and
// (per-run constant) flags into the list of control words the sequencer
// must issue, plus whether the watchdog must abort.
// ----------------------------------------------------------------------------
module tb_sc_microsequencer;
  import sc_microseq_pkg::*;

  localparam int WDMAX = 255;
  localparam logic [21:0] NOP = {4'hF, 4'hF, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 2'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ovf_n = 1'b1, carry_n = 1'b1, neg_n = 1'b1, zero_n = 1'b1;
  logic [3:0] dclr, dld, alu;
  logic [2:0] muxa, muxb;
  logic       shclr_n, shld_n;
  logic [1:0] shsel;
`ifdef SC_MICROSEQ_STEP_EN
  logic step = 1'b1;
`endif

  sc_microsequencer_if #(.PC_W(4), .INSTR_W(29)) bus ();

  sc_microsequencer dut (
    .SC_MICROSEQ_CLOCK_50                        (clk),
    .SC_MICROSEQ_RESET_InLow                     (rst_n),
`ifdef SC_MICROSEQ_STEP_EN
    .SC_MICROSEQ_step_In                         (step),
`endif
    .ctrl                                        (bus),
    .SC_MICROSEQ_overflow_InLow                  (ovf_n),
    .SC_MICROSEQ_carry_InLow                     (carry_n),
    .SC_MICROSEQ_negative_InLow                  (neg_n),
    .SC_MICROSEQ_zero_InLow                      (zero_n),
    .SC_MICROSEQ_decoderclearselection_OutBUS    (dclr),
    .SC_MICROSEQ_decoderloadselection_OutBUS     (dld),
    .SC_MICROSEQ_muxselectionBUSA_OutBUS         (muxa),
    .SC_MICROSEQ_muxselectionBUSB_OutBUS         (muxb),
    .SC_MICROSEQ_aluselection_OutBUS             (alu),
    .SC_MICROSEQ_regSHIFTERclear_OutLow          (shclr_n),
    .SC_MICROSEQ_regSHIFTERload_OutLow           (shld_n),
    .SC_MICROSEQ_regSHIFTERshiftselection_OutBUS (shsel)
  );

  logic [21:0] ctl_obs;
  assign ctl_obs = {dld, dclr, muxa, muxb, alu, shclr_n, shld_n, shsel};

  logic [28:0] mem [16];
  logic [21:0] exp_q [$];
  bit          exp_err;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [28:0] mk(int ld, int clr, int ma, int mb, int al,
                                     int scl, int sld, int ssel, int cond, int tgt);
    return {4'(ld), 4'(clr), 3'(ma), 3'(mb), 4'(al), 1'(scl), 1'(sld),
            2'(ssel), 3'(cond), 4'(tgt)};
  endfunction

  function automatic logic [28:0] rand_word();
    return 29'($urandom);
  endfunction

  // Reference: walk the program, collecting each issued control word.
  // fn = {ovf_n, carry_n, neg_n, zero_n}
  task automatic model(input int sa, input logic [3:0] fn);
    int pc;
    logic [28:0] w;
    int c;
    bit t;
    exp_q.delete();
    exp_err = 0;
    pc = sa;
    for (int k = 0; k < WDMAX; k++) begin
      if (k == WDMAX - 1) begin exp_err = 1; break; end
      w = mem[pc];
      c = int'(w[6:4]);
      if (c == 7) break;
      exp_q.push_back(w[28:7]);
      case (c)
        1: t = 1;
        2: t = !fn[0];
        3: t = !fn[1];
        4: t = !fn[2];
        5: t = !fn[3];
        6: t = fn[0];
        default: t = 0;
      endcase
      pc = t ? int'(w[3:0]) : (pc + 1) % 16;
    end
  endtask

  task automatic wr(input int a, input logic [28:0] w);
    bus.SC_MICROSEQ_progwrite_In   = 1'b1;
    bus.SC_MICROSEQ_progaddr_InBUS = 4'(a);
    bus.SC_MICROSEQ_progdata_InBUS = w;
    mem[a] = w;
    @(posedge clk); #1;
    bus.SC_MICROSEQ_progwrite_In = 1'b0;
  endtask

  // One complete run; optionally writes the entry word in the start cycle,
  // and optionally pokes a write + start into the middle of the run.
  task automatic run(input string name, input int sa, input logic [3:0] fn,
                     input bit wr_same, input logic [28:0] wword, input bit poke);
    int n;
    {ovf_n, carry_n, neg_n, zero_n} = fn;
    if (wr_same) mem[sa] = wword;
    model(sa, fn);
    n = exp_q.size();
    bus.SC_MICROSEQ_start_In       = 1'b1;
    bus.SC_MICROSEQ_startaddr_InBUS = 4'(sa);
    if (wr_same) begin
      bus.SC_MICROSEQ_progwrite_In   = 1'b1;
      bus.SC_MICROSEQ_progaddr_InBUS = 4'(sa);
      bus.SC_MICROSEQ_progdata_InBUS = wword;
    end
    @(posedge clk); #1;
    bus.SC_MICROSEQ_start_In     = 1'b0;
    bus.SC_MICROSEQ_progwrite_In = 1'b0;
    check_eq({name, "/busy_start"}, 32'(bus.SC_MICROSEQ_busy_Out), 1);
    check_eq({name, "/err_cleared"}, 32'(bus.SC_MICROSEQ_error_Out), 0);
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      if (k < n) begin
        check_eq({name, "/ctl"}, 32'(ctl_obs), 32'(exp_q[k]));
        check_eq({name, "/busy"}, 32'(bus.SC_MICROSEQ_busy_Out), 1);
      end else begin
        check_eq({name, "/ctl_end"}, 32'(ctl_obs), 32'(NOP));
        check_eq({name, "/busy_end"}, 32'(bus.SC_MICROSEQ_busy_Out), 0);
        check_eq({name, "/error"}, 32'(bus.SC_MICROSEQ_error_Out), 32'(exp_err));
        check_eq({name, "/done_early"}, 32'(bus.SC_MICROSEQ_done_Out), 0);
      end
      if (poke && k == 2) begin
        bus.SC_MICROSEQ_progwrite_In    = 1'b1;
        bus.SC_MICROSEQ_progaddr_InBUS  = 4'd1;
        bus.SC_MICROSEQ_progdata_InBUS  = ~mem[1];
        bus.SC_MICROSEQ_start_In        = 1'b1;
        bus.SC_MICROSEQ_startaddr_InBUS = 4'd7;
      end
      if (poke && k == 3) begin
        bus.SC_MICROSEQ_progwrite_In = 1'b0;
        bus.SC_MICROSEQ_start_In     = 1'b0;
      end
    end
    @(posedge clk); #1;
    check_eq({name, "/done"}, 32'(bus.SC_MICROSEQ_done_Out), 1);
    check_eq({name, "/ctl_done"}, 32'(ctl_obs), 32'(NOP));
    @(posedge clk); #1;
    check_eq({name, "/done_pulse"}, 32'(bus.SC_MICROSEQ_done_Out), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.SC_MICROSEQ_start_In        = 1'b0;
    bus.SC_MICROSEQ_startaddr_InBUS = '0;
    bus.SC_MICROSEQ_progwrite_In    = 1'b0;
    bus.SC_MICROSEQ_progaddr_InBUS  = '0;
    bus.SC_MICROSEQ_progdata_InBUS  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/ctl", 32'(ctl_obs), 32'(NOP));
    check_eq("reset/busy", 32'(bus.SC_MICROSEQ_busy_Out), 0);
    check_eq("reset/done", 32'(bus.SC_MICROSEQ_done_Out), 0);
    check_eq("reset/error", 32'(bus.SC_MICROSEQ_error_Out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the store with halts so every address is defined.
    for (int a = 0; a < 16; a++) wr(a, mk(15, 15, 0, 0, 0, 1, 1, 0, 7, 0));

    // Two-word program: issue alu=2/load=1, then halt.
    wr(0, mk(1, 15, 0, 0, 2, 1, 1, 0, 0, 0));
    wr(1, mk(15, 15, 0, 0, 0, 1, 1, 0, 7, 0));
    run("basic", 0, 4'hF, 0, '0, 0);

    // Conditional branch on zero: to 5 when zero asserted, else fall to 1.
    wr(0, mk(15, 15, 1, 1, 4, 1, 1, 0, 2, 5));
    wr(5, mk(2, 15, 0, 0, 5, 1, 1, 0, 0, 0));
    wr(6, mk(15, 15, 0, 0, 0, 1, 1, 0, 7, 0));
    wr(1, mk(3, 15, 0, 0, 1, 1, 1, 0, 0, 0));
    wr(2, mk(15, 15, 0, 0, 0, 1, 1, 0, 7, 0));
    run("bz_taken", 0, 4'b1110, 0, '0, 0);
    run("bz_fall", 0, 4'b1111, 0, '0, 0);

    // PC wraps from 15 to 0.
    wr(15, mk(4, 15, 2, 3, 3, 1, 1, 1, 0, 9));
    wr(0, mk(5, 15, 0, 0, 6, 0, 1, 0, 0, 0));
    run("wrap", 15, 4'hF, 0, '0, 0);

    // Tight loop at 4 runs into the watchdog; second time with a write and
    // a start attempted mid-run, both of which must be ignored.
    wr(4, mk(2, 15, 1, 2, 7, 1, 0, 1, 1, 4));
    run("wdog", 4, 4'hF, 0, '0, 0);
    run("wdog_poke", 4, 4'hF, 0, '0, 1);
    run("store_kept", 1, 4'hF, 0, '0, 0);

    // Reset in the middle of a run.
    wr(3, mk(6, 15, 0, 0, 9, 1, 1, 0, 1, 3));
    bus.SC_MICROSEQ_start_In        = 1'b1;
    bus.SC_MICROSEQ_startaddr_InBUS = 4'd3;
    @(posedge clk); #1;
    bus.SC_MICROSEQ_start_In = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst/ctl_run", 32'(ctl_obs), 32'(mem[3][28:7]));
    rst_n = 1'b0;
    #1;
    check_eq("midrst/ctl", 32'(ctl_obs), 32'(NOP));
    check_eq("midrst/busy", 32'(bus.SC_MICROSEQ_busy_Out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("midrst/no_done", 32'(bus.SC_MICROSEQ_done_Out), 0);
      check_eq("midrst/idle", 32'(bus.SC_MICROSEQ_busy_Out), 0);
    end
    run("after_rst", 1, 4'hF, 0, '0, 0);

    // Randomized programs, flags and entry points.
    for (int r = 0; r < 24; r++) begin
      for (int a = 0; a < 16; a++) wr(a, rand_word());
      run($sformatf("rand%0d", r), int'($urandom_range(0, 15)), 4'($urandom),
          bit'($urandom_range(0, 1)), rand_word(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_microsequencer.md
Name: sc_microsequencer

Overview:
Parametrised microprogrammed control unit that drives every uDATAPATH control bus from a writable microprogram store, replacing the hard-wired state machine position in BB_SYSTEM. Adds start/busy/done handshake, flag-conditional branching on the datapath's active-low flags, and a watchdog abort. It sits between the system top and uDATAPATH; its outputs connect one-to-one to the datapath control inputs.

Parameters:
DATAWIDTH_DECODER_SELECTION, 4, clear/load register-select code width
DATAWIDTH_MUX_SELECTION, 3, BUS_A/BUS_B mux select width
DATAWIDTH_ALU_SELECTION, 4, ALU operation select width
DATAWIDTH_REGSHIFTER_SELECTION, 2, shifter mode select width
PROGRAM_DEPTH, 16, microinstruction words (power of 2, >=2)
DECODER_NOP, all ones, decoder code meaning "no register selected"
WATCHDOG_MAX, 255, RUN cycles before abort (8-bit counter)

Ports:
SC_MICROSEQ_CLOCK_50  in  1  system clock
SC_MICROSEQ_RESET_InLow  in  1  reset, asynchronous, active-low
SC_MICROSEQ_start_In  in  1  start pulse, sampled in IDLE only
SC_MICROSEQ_startaddr_InBUS  in  PC_W  entry address (PC_W = clog2(PROGRAM_DEPTH))
SC_MICROSEQ_progwrite_In  in  1  program-store write enable
SC_MICROSEQ_progaddr_InBUS  in  PC_W  write address
SC_MICROSEQ_progdata_InBUS  in  INSTR_W  microinstruction word
SC_MICROSEQ_overflow_InLow / carry_InLow / negative_InLow / zero_InLow  in  1 each  datapath flags, active-low
SC_MICROSEQ_decoderclearselection_OutBUS, decoderloadselection_OutBUS  out  DATAWIDTH_DECODER_SELECTION
SC_MICROSEQ_muxselectionBUSA_OutBUS, muxselectionBUSB_OutBUS  out  DATAWIDTH_MUX_SELECTION
SC_MICROSEQ_aluselection_OutBUS  out  DATAWIDTH_ALU_SELECTION
SC_MICROSEQ_regSHIFTERclear_OutLow, regSHIFTERload_OutLow  out  1  active-low
SC_MICROSEQ_regSHIFTERshiftselection_OutBUS  out  DATAWIDTH_REGSHIFTER_SELECTION
SC_MICROSEQ_busy_Out  out  1  high in RUN
SC_MICROSEQ_done_Out  out  1  one-cycle pulse on completion
SC_MICROSEQ_error_Out  out  1  watchdog abort, sticky until next accepted start

Behaviour:
- Word, MSB->LSB: load_sel, clear_sel, muxA, muxB, alu, shclr_n, shld_n, shsel, cond[2:0], target[PC_W-1:0]; INSTR_W = 2*DEC+2*MUX+ALU+2+SH+3+PC_W (29 at defaults).
- cond: 0 next, 1 jump, 2 jump if zero, 3 if negative, 4 if carry, 5 if overflow, 6 if not zero, 7 halt. Flags inverted internally; they reflect the previously issued microinstruction.
- NOP output set: decoder buses = DECODER_NOP, mux/alu/shsel = 0, shifter _OutLow = 1. Reset value of all control outputs = NOP; busy/done/error = 0; PC = 0; state IDLE.
- States: IDLE, RUN, DONE.
- IDLE: outputs NOP. start -> PC <= startaddr, watchdog <= 0, error <= 0, -> RUN.
- RUN, each cycle: word = store[PC]. cond != 7: control outputs registered from word (visible next edge, one-cycle latency PC->outputs); PC <= taken ? target : PC+1 (wraps modulo PROGRAM_DEPTH). cond == 7: outputs <= NOP, -> DONE.
- Watchdog increments per RUN cycle; at WATCHDOG_MAX: outputs <= NOP, error <= 1, -> DONE (takes priority over halt that cycle).
- DONE: done = 1 one cycle, busy = 0, -> IDLE.
- Program writes accepted only in IDLE (ignored otherwise); write + start same IDLE cycle: both take effect, first fetch sees new word. start outside IDLE ignored. Store not reset (contents survive reset).
- Reset mid-RUN: immediate NOP outputs, IDLE, no done pulse.

Optional Feature:
SC_MICROSEQ_STEP_EN: adds input SC_MICROSEQ_step_In; in RUN, PC/outputs/watchdog advance only on cycles with step = 1, otherwise outputs hold the last issued word. Without macro: port absent, one instruction per cycle.

Decomposition:
Package sc_microseq_pkg: cond encodings, state enum, field offsets/INSTR_W function, NOP constants. Sub-module sc_microseq_store (PROGRAM_DEPTH x INSTR_W, sync write, async read).

Test Plan:
- Reset asserted mid-RUN at addr 3 -> outputs NOP (decoders 4'hF, shifter_n 1), busy 0, no done.
- Program 0:alu=2,load=1,next; 1:halt; start @0 -> cycle+1 alu=2/load=1, cycle+2 NOP, done pulse cycle+3, busy 2 cycles.
- Addr 0: cond=2 target 5, zero_InLow=0 -> PC 5; repeat zero_InLow=1 -> PC 1.
- Start at 15, word 15 cond=0 -> PC wraps to 0.
- Word 4 cond=1 target 4, WATCHDOG_MAX=255 -> error=1, done after 255 RUN cycles, outputs NOP.
- progwrite during RUN to addr 1 -> store unchanged; start while busy -> ignored.
